// File: rtl/glb_access_arbiter.sv
// glb_access_arbiter
// Shared-port controller in front of the global buffer. Arbitrates word accesses from
// the IFMAP loader (client 0), PSUM engine (client 1) and WGHT loader (client 2)
// round-robin. Each client's logical address is turned into a physical bank/row using
// the per-type bank allocation, and one registered access per cycle goes to the banks.
// The allocation register is reloaded only after in-flight accesses have drained.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cfg_valid/_allocation   allocation load {ifmap_cnt, psum_cnt, wght_cnt}
//   o_cfg_ready               config consumed (same cycle as the load)
//   i_req_valid/we/addr/wdata per-client request buses
//   o_req_ready               one-hot combinational grant
//   o_glb_en/we/bank_sel/addr/wdata  registered GLB access (cycle after grant)
//   i_glb_rdata               bank read data, one cycle after a read strobe
//   o_rdata, o_rdata_valid    read data pass-through plus one-hot owning client
//   o_err, o_err_code         error pulse; code 0..2 = client out of range, 3 = bad config
module glb_access_arbiter #(
   parameter  int DATA_BITWIDTH = 32,
   parameter  int BANK_NUM      = 27,
   parameter  int BANK_DEPTH    = 512,
   localparam int BW            = $clog2(BANK_NUM + 1),
   localparam int AW            = $clog2(BANK_NUM * BANK_DEPTH + 1),
   localparam int RW            = $clog2(BANK_DEPTH + 1)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_cfg_valid,
   input  logic [3*BW-1:0]            i_cfg_allocation,
   output logic                       o_cfg_ready,
   input  logic [2:0]                 i_req_valid,
   input  logic [2:0]                 i_req_we,
   input  logic [3*AW-1:0]            i_req_addr,
   input  logic [3*DATA_BITWIDTH-1:0] i_req_wdata,
   output logic [2:0]                 o_req_ready,
   output logic                       o_glb_en,
   output logic                       o_glb_we,
   output logic [BW-1:0]              o_glb_bank_sel,
   output logic [RW-1:0]              o_glb_addr,
   output logic [DATA_BITWIDTH-1:0]   o_glb_wdata,
   input  logic [DATA_BITWIDTH-1:0]   i_glb_rdata,
   output logic [DATA_BITWIDTH-1:0]   o_rdata,
   output logic [2:0]                 o_rdata_valid,
   output logic                       o_err,
   output logic [1:0]                 o_err_code
);

   // BANK_DEPTH is a power of two, so the row is the low RW-1 address bits
   // and the bank index is everything above them.
   localparam int IW = AW - RW + 1;
   localparam int CW = ((IW > BW) ? IW : BW) + 1;

   typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

   state_t              state, state_nx;
   logic [3*BW-1:0]     alloc;
   logic [1:0]          rr_ptr;
   logic [2:0]          tag1;
   logic                grant_en, cfg_load, busy;

   logic [BW-1:0]       cnt_i, cnt_p, cnt_w;
   logic [BW-1:0]       new_i, new_p, new_w;
   logic [BW+1:0]       cfg_sum;
   logic                cfg_ok;

   logic                gvalid;
   logic [1:0]          gidx;
   logic [2:0]          gnt;
   int                  cand;

   logic [AW-1:0]       sel_addr;
   logic                sel_we;
   logic [DATA_BITWIDTH-1:0] sel_wdata;
   logic [IW-1:0]       bank_idx;
   logic [RW-1:0]       row;
   logic [BW-1:0]       cnt_sel, base_sel, phys_bank;
   logic                in_range;

   assign {cnt_i, cnt_p, cnt_w} = alloc;
   assign {new_i, new_p, new_w} = i_cfg_allocation;

   assign cfg_sum = (BW+2)'(new_i) + (BW+2)'(new_p) + (BW+2)'(new_w);
   assign cfg_ok  = (cfg_sum <= (BW+2)'(BANK_NUM));

   // Anything still in the pipe: a strobe, a tag waiting for bank data, or data returning.
   assign busy = o_glb_en | (|tag1) | (|o_rdata_valid);

   always_comb begin
      state_nx = state;
      grant_en = 1'b0;
      cfg_load = 1'b0;
      case (state)
         UNCFG: begin
            if (i_cfg_valid) begin
               cfg_load = 1'b1;
               if (cfg_ok) state_nx = RUN;
            end
         end
         RUN: begin
            // A pending config takes precedence over any request this cycle.
            if (i_cfg_valid) state_nx = DRAIN;
            else             grant_en = 1'b1;
         end
         DRAIN: begin
            // Reload uses whatever allocation is presented now, even if valid dropped.
            if (!busy) begin
               cfg_load = 1'b1;
               state_nx = RUN;
            end
         end
         default: state_nx = UNCFG;
      endcase
      if (!i_rst_n) begin
         grant_en = 1'b0;
         cfg_load = 1'b0;
      end
   end

   // Round-robin: scan from rr_ptr, first valid client wins.
   always_comb begin
      gvalid = 1'b0;
      gidx   = 2'd0;
      cand   = 0;
      if (grant_en) begin
         for (int k = 0; k < 3; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand > 2) cand = cand - 3;
            if (!gvalid && i_req_valid[cand]) begin
               gvalid = 1'b1;
               gidx   = 2'(cand);
            end
         end
      end
   end

   assign gnt         = gvalid ? (3'b001 << gidx) : 3'b000;
   assign o_req_ready = gnt;
   assign o_cfg_ready = cfg_load;
   assign o_rdata     = i_glb_rdata;

   // Address decode for the granted client.
   assign sel_addr  = i_req_addr[gidx*AW +: AW];
   assign sel_we    = i_req_we[gidx];
   assign sel_wdata = i_req_wdata[gidx*DATA_BITWIDTH +: DATA_BITWIDTH];
   assign bank_idx  = sel_addr[AW-1:RW-1];
   assign row       = {1'b0, sel_addr[RW-2:0]};

   always_comb begin
      cnt_sel  = cnt_w;
      base_sel = cnt_i + cnt_p;
      case (gidx)
         2'd0:    begin cnt_sel = cnt_i; base_sel = '0;    end
         2'd1:    begin cnt_sel = cnt_p; base_sel = cnt_i; end
         default: begin cnt_sel = cnt_w; base_sel = cnt_i + cnt_p; end
      endcase
   end

   assign in_range  = (CW'(bank_idx) < CW'(cnt_sel));
   assign phys_bank = BW'(CW'(base_sel) + CW'(bank_idx));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state          <= UNCFG;
         alloc          <= '0;
         rr_ptr         <= 2'd0;
         tag1           <= '0;
         o_glb_en       <= 1'b0;
         o_glb_we       <= 1'b0;
         o_glb_bank_sel <= '0;
         o_glb_addr     <= '0;
         o_glb_wdata    <= '0;
         o_rdata_valid  <= '0;
         o_err          <= 1'b0;
         o_err_code     <= 2'd0;
      end else begin
         state <= state_nx;
         if (cfg_load && cfg_ok) alloc <= i_cfg_allocation;

         if (gvalid) rr_ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

         o_glb_en <= gvalid & in_range;
         if (gvalid && in_range) begin
            o_glb_we       <= sel_we;
            o_glb_bank_sel <= phys_bank;
            o_glb_addr     <= row;
            o_glb_wdata    <= sel_wdata;
         end

         // Two-stage read tag: strobe cycle, then data-return cycle.
         tag1          <= (gvalid && in_range && !sel_we) ? gnt : 3'b000;
         o_rdata_valid <= tag1;

         o_err <= 1'b0;
         if (cfg_load && !cfg_ok) begin
            o_err      <= 1'b1;
            o_err_code <= 2'd3;
         end else if (gvalid && !in_range) begin
            o_err      <= 1'b1;
            o_err_code <= gidx;
         end
      end
   end

endmodule

// File: tb/tb_glb_access_arbiter.sv
// Scoreboard bench for glb_access_arbiter: directed stimulus, expectations queued
// at grant time from a bench-side decode model and popped by a monitor.
module tb_glb_access_arbiter;
   localparam int DW = 32;
   localparam int BW = 5;
   localparam int AW = 14;
   localparam int RW = 10;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_cfg_valid = 1'b0;
   logic [3*BW-1:0]   i_cfg_allocation = '0;
   logic              o_cfg_ready;
   logic [2:0]        i_req_valid = '0;
   logic [2:0]        i_req_we = '0;
   logic [3*AW-1:0]   i_req_addr = '0;
   logic [3*DW-1:0]   i_req_wdata = '0;
   logic [2:0]        o_req_ready;
   logic              o_glb_en, o_glb_we;
   logic [BW-1:0]     o_glb_bank_sel;
   logic [RW-1:0]     o_glb_addr;
   logic [DW-1:0]     o_glb_wdata;
   logic [DW-1:0]     i_glb_rdata = '0;
   logic [DW-1:0]     o_rdata;
   logic [2:0]        o_rdata_valid;
   logic              o_err;
   logic [1:0]        o_err_code;

   glb_access_arbiter dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_cfg_valid(i_cfg_valid), .i_cfg_allocation(i_cfg_allocation), .o_cfg_ready(o_cfg_ready),
      .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata), .o_req_ready(o_req_ready),
      .o_glb_en(o_glb_en), .o_glb_we(o_glb_we), .o_glb_bank_sel(o_glb_bank_sel),
      .o_glb_addr(o_glb_addr), .o_glb_wdata(o_glb_wdata), .i_glb_rdata(i_glb_rdata),
      .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_err(o_err), .o_err_code(o_err_code)
   );

   always #5 i_clk = ~i_clk;

   // GLB bank model: read data encodes the bank and row that were strobed.
   always @(posedge i_clk)
      if (o_glb_en && !o_glb_we) i_glb_rdata <= 32'hA500_0000 | 32'({o_glb_bank_sel, o_glb_addr});

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int m_ifm = 0, m_ps = 0, m_wg = 0;

   typedef struct { int cyc; logic we; logic [4:0] bank; logic [9:0] row; logic [31:0] wd; } gexp_t;
   typedef struct { int cyc; logic [2:0] tag; logic [31:0] data; } rexp_t;
   typedef struct { int cyc; logic [1:0] code; } eexp_t;
   gexp_t q_glb[$];
   rexp_t q_rd[$];
   eexp_t q_err[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic void dec(input int c, input int a, output bit ok, output int bank, output int row);
      int idx, cnt, base;
      idx  = a / 512;
      row  = a % 512;
      cnt  = (c == 0) ? m_ifm : ((c == 1) ? m_ps : m_wg);
      base = (c == 0) ? 0 : ((c == 1) ? m_ifm : m_ifm + m_ps);
      ok   = idx < cnt;
      bank = base + idx;
   endfunction

   // Monitor: retire overdue expectations, compare presented outputs, then queue
   // expectations for any handshake happening this cycle.
   always @(negedge i_clk) begin
      bit ok;
      int bank, row, a;
      gexp_t g;
      rexp_t r;
      eexp_t e;
      while (q_glb.size() > 0 && q_glb[0].cyc < cyc) begin g = q_glb.pop_front(); fail("glb_missing", 0, 64'(g.bank)); end
      while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin r = q_rd.pop_front(); fail("rdata_missing", 0, 64'(r.tag)); end
      while (q_err.size() > 0 && q_err[0].cyc < cyc) begin e = q_err.pop_front(); fail("err_missing", 0, 64'(e.code)); end

      if (o_glb_en === 1'b1) begin
         if (q_glb.size() > 0 && q_glb[0].cyc == cyc) begin
            g = q_glb.pop_front();
            chk("glb_access", {o_glb_we, o_glb_bank_sel, o_glb_addr, o_glb_wdata}, {g.we, g.bank, g.row, g.wd});
         end else fail("glb_unexpected", {o_glb_bank_sel, o_glb_addr}, 0);
      end
      if (o_rdata_valid !== 3'b000 && !$isunknown(o_rdata_valid)) begin
         if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
            r = q_rd.pop_front();
            chk("rdata", {o_rdata_valid, o_rdata}, {r.tag, r.data});
         end else fail("rdata_unexpected", 64'(o_rdata_valid), 0);
      end
      if (o_err === 1'b1) begin
         if (q_err.size() > 0 && q_err[0].cyc == cyc) begin
            e = q_err.pop_front();
            chk("err_code", 64'(o_err_code), 64'(e.code));
         end else fail("err_unexpected", 64'(o_err_code), 0);
      end
      if (o_req_ready !== 3'b000 && !$isunknown(o_req_ready)) chk("ready_onehot", 64'($onehot(o_req_ready)), 1);

      for (int c = 0; c < 3; c++) begin
         if (i_req_valid[c] && o_req_ready[c] === 1'b1) begin
            a = int'(i_req_addr[c*AW +: AW]);
            dec(c, a, ok, bank, row);
            if (ok) begin
               q_glb.push_back('{cyc + 1, i_req_we[c], 5'(bank), 10'(row), i_req_wdata[c*DW +: DW]});
               if (!i_req_we[c]) q_rd.push_back('{cyc + 2, 3'(1 << c), 32'hA500_0000 | 32'(bank * 1024 + row)});
            end else q_err.push_back('{cyc + 1, 2'(c)});
         end
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic req(input int c, input bit we, input int addr, input logic [31:0] wd,
                      input bit exp_en, input int exp_bank, input int exp_row);
      bit got;
      got = 0;
      i_req_we[c] = we;
      i_req_addr[c*AW +: AW] = AW'(addr);
      i_req_wdata[c*DW +: DW] = wd;
      i_req_valid[c] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge i_clk);
         if (o_req_ready[c]) begin got = 1; break; end
         @(posedge i_clk); #1;
      end
      if (!got) fail("grant_timeout", 0, 64'(c));
      @(posedge i_clk); #1;
      i_req_valid[c] = 1'b0;
      @(negedge i_clk);
      chk("glb_en", 64'(o_glb_en), 64'(exp_en));
      if (exp_en) chk("glb_decode", {o_glb_bank_sel, o_glb_addr, o_glb_we}, {5'(exp_bank), 10'(exp_row), we});
      @(posedge i_clk); #1;
   endtask

   task automatic cfg(input int ci, input int cp, input int cw, input bit ok);
      bit seen;
      seen = 0;
      i_cfg_allocation = {5'(ci), 5'(cp), 5'(cw)};
      i_cfg_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge i_clk);
         if (o_cfg_ready) begin
            seen = 1;
            if (ok) begin m_ifm = ci; m_ps = cp; m_wg = cw; end
            else q_err.push_back('{cyc + 1, 2'd3});
            break;
         end
         @(posedge i_clk); #1;
      end
      chk("cfg_ready", 64'(seen), 1);
      @(posedge i_clk); #1;
      i_cfg_valid = 1'b0;
   endtask

   logic [2:0] rr_exp [6];
   int wait_n;

   initial begin
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      // Reset values
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("reset_outputs", {o_glb_en, o_glb_we, o_glb_bank_sel, o_glb_addr, o_glb_wdata, o_rdata_valid,
                            o_err, o_err_code, o_cfg_ready, o_req_ready}, 0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;

      // Unconfigured: no grants
      i_req_valid = 3'b111;
      for (int n = 0; n < 4; n++) begin
         @(negedge i_clk);
         chk("uncfg_ready", 64'(o_req_ready), 0);
         @(posedge i_clk); #1;
      end
      i_req_valid = 3'b000;

      // Nominal decode with 9/9/9
      cfg(9, 9, 9, 1);
      req(0, 0, 700,  32'h0,         1, 1,  188);
      req(1, 1, 5,    32'hDEAD_BEEF, 1, 9,  5);
      req(2, 0, 1030, 32'h0,         1, 20, 6);

      // Round-robin with all three clients reading
      i_req_we = 3'b000;
      i_req_addr = {AW'(1030), AW'(5), AW'(700)};
      i_req_valid = 3'b111;
      for (int n = 0; n < 6; n++) begin
         @(negedge i_clk);
         chk("rr_grant", 64'(o_req_ready), 64'(rr_exp[n]));
         @(posedge i_clk); #1;
      end
      i_req_valid = 3'b000;
      repeat (3) @(posedge i_clk); #1;

      // Out-of-range IFMAP: granted, no strobe, err code 0
      req(0, 0, 4608, 32'h0, 0, 0, 0);

      // Bad config: err code 3, allocation kept (PSUM addr 5 still bank 9)
      cfg(20, 5, 5, 0);
      req(1, 1, 5, 32'h1234_5678, 1, 9, 5);
      repeat (2) @(posedge i_clk); #1;

      // Reconfigure under continuous PSUM reads
      i_req_we[1] = 1'b0;
      i_req_addr[AW +: AW] = AW'(3);
      i_req_valid[1] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge i_clk);
         chk("load_grant", 64'(o_req_ready), 3'b010);
         @(posedge i_clk); #1;
      end
      i_cfg_allocation = {5'd4, 5'd10, 5'd13};
      i_cfg_valid = 1'b1;
      wait_n = -1;
      for (int n = 0; n < 8; n++) begin
         @(negedge i_clk);
         chk("drain_no_grant", 64'(o_req_ready), 0);
         if (o_cfg_ready) begin
            wait_n = n;
            m_ifm = 4; m_ps = 10; m_wg = 13;
            break;
         end
         @(posedge i_clk); #1;
      end
      chk("drain_cycles", 64'(wait_n), 2);
      @(posedge i_clk); #1;
      i_cfg_valid = 1'b0;
      i_req_addr[AW +: AW] = AW'(0);
      @(negedge i_clk);
      chk("reload_grant", 64'(o_req_ready), 3'b010);
      @(posedge i_clk); #1;
      i_req_valid[1] = 1'b0;
      @(negedge i_clk);
      chk("reload_bank", {o_glb_en, o_glb_bank_sel, o_glb_addr}, {1'b1, 5'd4, 10'd0});
      repeat (3) @(posedge i_clk); #1;

      // Reset pulsed during an IFMAP read
      i_req_we[0] = 1'b0;
      i_req_addr[0 +: AW] = AW'(0);
      i_req_valid[0] = 1'b1;
      @(negedge i_clk);
      chk("rst_grant", 64'(o_req_ready), 3'b001);
      @(posedge i_clk); #1;
      i_req_valid[0] = 1'b0;
      i_rst_n = 1'b0;
      q_rd.delete();
      @(negedge i_clk);
      chk("rst_strobe", 64'(o_glb_en), 1);
      for (int n = 0; n < 2; n++) begin
         @(posedge i_clk); #1;
         @(negedge i_clk);
         chk("rst_flush_rdv", 64'(o_rdata_valid), 0);
         chk("rst_outputs", {o_glb_en, o_glb_we, o_glb_bank_sel, o_glb_addr, o_glb_wdata, o_rdata_valid,
                             o_err, o_err_code, o_cfg_ready, o_req_ready}, 0);
      end
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      m_ifm = 0; m_ps = 0; m_wg = 0;
      i_req_valid = 3'b010;
      for (int n = 0; n < 2; n++) begin
         @(negedge i_clk);
         chk("post_rst_uncfg", 64'(o_req_ready), 0);
         @(posedge i_clk); #1;
      end
      i_req_valid = 3'b000;

      repeat (4) @(posedge i_clk); #1;
      chk("glb_queue_empty", 64'(q_glb.size()), 0);
      chk("rd_queue_empty", 64'(q_rd.size()), 0);
      chk("err_queue_empty", 64'(q_err.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/glb_access_arbiter.md
# glb_access_arbiter

Shared-port controller in front of the global buffer (GLB). It arbitrates word accesses from the three GLB clients (IFMAP loader, PSUM engine, WGHT loader) round-robin, translates each client's logical address into a physical bank and row using the per-type bank allocation, and issues one registered access per cycle to the GLB banks. It also holds the allocation register and reloads it safely by draining in-flight accesses first.

## Interface
Width function: clogb2(x) = floor(log2 x)+1. BW = clogb2(BANK_NUM), AW = clogb2(BANK_NUM*BANK_DEPTH), RW = clogb2(BANK_DEPTH). With defaults, BW=5, AW=14, RW=10.

Parameters:
- DATA_BITWIDTH, 32, GLB word width
- BANK_NUM, 27, number of GLB banks
- BANK_DEPTH, 512, words per bank (power of two)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  synchronous, active-low reset
- i_cfg_valid  in  1  allocation load request
- i_cfg_allocation  in  3*BW  {ifmap_cnt, psum_cnt, wght_cnt}
- o_cfg_ready  out  1  one-cycle pulse: config consumed
- i_req_valid  in  3  per client; bit0 IFMAP, bit1 PSUM, bit2 WGHT
- i_req_we  in  3  1 = write
- i_req_addr  in  3*AW  logical address per client; client c uses slice [c*AW +: AW]
- i_req_wdata  in  3*DATA_BITWIDTH  write data per client
- o_req_ready  out  3  one-hot grant, combinational
- o_glb_en  out  1  GLB access strobe
- o_glb_we  out  1  GLB write enable
- o_glb_bank_sel  out  BW  physical bank
- o_glb_addr  out  RW  row within the bank
- o_glb_wdata  out  DATA_BITWIDTH  GLB write data
- i_glb_rdata  in  DATA_BITWIDTH  bank read data, valid 1 cycle after a read strobe
- o_rdata  out  DATA_BITWIDTH  equals i_glb_rdata (pass-through)
- o_rdata_valid  out  3  one-hot; marks the client that owns o_rdata
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  0/1/2 = client with out-of-range address; 3 = bad config

## Operation
- FSM states:
  - UNCFG (reset state): all o_req_ready are 0.
  - RUN: requests are granted.
  - DRAIN: no grants; waits for in-flight accesses to finish.
- Transitions:
  - UNCFG + i_cfg_valid: load config the same cycle, pulse o_cfg_ready, go to RUN.
  - RUN + i_cfg_valid: go to DRAIN. No grant is issued in that cycle.
  - DRAIN: once no GLB strobe and no read tag are outstanding, load config, pulse o_cfg_ready, return to RUN.
- Config check: if ifmap_cnt+psum_cnt+wght_cnt > BANK_NUM (sum computed at BW+2 bits):
  - the old allocation is kept;
  - o_cfg_ready still pulses;
  - o_err pulses with o_err_code=3;
  - if the FSM was in UNCFG, it stays in UNCFG.
- Arbitration: round-robin across the clients. After reset, the priority order is IFMAP>PSUM>WGHT. After a grant to client c, client (c+1) mod 3 has highest priority. At most one grant per cycle.
- Handshake: a transfer happens when i_req_valid[c] & o_req_ready[c]. A requester holds valid, addr, we and wdata stable until granted.
- Decode:
  - bank_idx = addr / BANK_DEPTH; row = addr % BANK_DEPTH.
  - Base bank per type: ifmap = 0; psum = ifmap_cnt; wght = ifmap_cnt + psum_cnt.
  - Physical bank = base + bank_idx.
- Range check: bank_idx >= that type's count makes the access out of range. The request is still granted (ready=1) but:
  - no GLB strobe is issued;
  - o_err pulses the next cycle with o_err_code=c;
  - no o_rdata_valid is produced.

## Timing
- Cycle T: grant (handshake).
- Cycle T+1: o_glb_en=1 with registered we, bank_sel, addr and wdata.
- Reads only: at T+2, o_rdata_valid[c]=1 for one cycle, driven from a registered client tag; o_rdata is i_glb_rdata.
- Throughput: 1 access per cycle. Back-to-back grants can overlap read returns; the tag pipeline is 2 stages deep.
- Reset values: o_glb_en=0, o_glb_we=0, o_glb_bank_sel=0, o_glb_addr=0, o_glb_wdata=0, o_rdata_valid=0, o_err=0, o_err_code=0, o_cfg_ready=0, o_req_ready=0. Allocation register resets to 0; RR pointer resets to IFMAP; FSM resets to UNCFG.
- Reset asserted mid-access: the pipeline is flushed at the next edge, and no o_rdata_valid appears afterwards.
- i_cfg_valid while a request is pending in RUN: config wins; grants are suspended until the reload completes.
- DRAIN lasts at most 2 cycles: 2 if a read tag is in flight, 1 if only a strobe is, 0 if the pipeline is already empty.
- If i_cfg_valid deasserts while in DRAIN, the reload still completes using the currently presented allocation. Requesters must hold i_cfg_valid until o_cfg_ready.

## Test plan
- Nominal decode (config 9/9/9, then access by each client): IFMAP read addr 700 → bank 1 row 188, o_rdata_valid=3'b001 at T+2. PSUM write addr 5 → bank 9 row 5, we=1. WGHT read addr 1030 → bank 20 row 6.
- Round-robin: all three clients valid for 6 cycles → grants IFMAP, PSUM, WGHT, IFMAP, PSUM, WGHT. Read returns carry matching one-hot tags in order.
- Out-of-range: config 9/9/9, IFMAP addr 4608 → granted, no o_glb_en, o_err=1 with code 0 at T+1, no rdata_valid. Config 20/5/5 → o_err with code 3, old allocation retained.
- Reconfigure under load: continuous PSUM reads, then i_cfg_valid with 4/10/13 → grants stop, last read data returns, o_cfg_ready pulses, PSUM addr 0 then maps to bank 4.
- Unconfigured: requests before any config → o_req_ready stays 0. Reset pulsed during a read → no o_rdata_valid and all outputs at their reset values.
